// File: rtl/riscv_core_dmem_responder.sv
// -----------------------------------------------------------------------------
// riscv_core_dmem_responder
//
// Memory-side responder for the data-cache controller's external channels.
// Backed by a word-addressed store of MEM_DEPTH_WORDS x CORE_DATA_WIDTH.
//
//   Read channel : line refill. After READ_LATENCY wait cycles, four words are
//                  fetched one per cycle into an internal line buffer, then the
//                  whole line is presented on o_mem_read_data together with a
//                  one-cycle o_mem_read_done pulse. The line is held until the
//                  next read completes.
//   Write channel: single write-through store. Address, data and size strobe
//                  are captured, and after WRITE_LATENCY wait cycles the store
//                  is merged into the addressed word under a byte mask, followed
//                  by a one-cycle o_mem_write_done pulse.
//
// Ports
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_mem_read_req        level read request, held until done
//   i_mem_read_address    line address (bits 4:0 ignored)
//   o_mem_read_done       one-cycle read completion pulse
//   o_mem_read_data       returned line, word n in bits 64n+63:64n
//   i_mem_write_valid     level write request, held until done
//   i_mem_write_address   byte address of the store
//   i_mem_write_data      right-aligned store value
//   i_mem_write_strobe    right-aligned size mask (0x01/0x03/0x0F/0xFF)
//   o_mem_write_done      one-cycle write completion pulse
//   o_busy                high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module riscv_core_dmem_responder #(
  parameter int ADDR_WIDTH      = 64,
  parameter int CORE_DATA_WIDTH = 64,
  parameter int AXI_DATA_WIDTH  = 256,
  parameter int MEM_DEPTH_WORDS = 4096,
  parameter int READ_LATENCY    = 4,
  parameter int WRITE_LATENCY   = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_mem_read_req,
  input  logic [ADDR_WIDTH-1:0]      i_mem_read_address,
  output logic                       o_mem_read_done,
  output logic [AXI_DATA_WIDTH-1:0]  o_mem_read_data,
  input  logic                       i_mem_write_valid,
  input  logic [ADDR_WIDTH-1:0]      i_mem_write_address,
  input  logic [CORE_DATA_WIDTH-1:0] i_mem_write_data,
  input  logic [7:0]                 i_mem_write_strobe,
  output logic                       o_mem_write_done,
  output logic                       o_busy
);

  localparam int IDX_W   = $clog2(MEM_DEPTH_WORDS);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  // The wait counter is loaded with latency-1 and the wait state is left when
  // it reads zero, giving exactly LATENCY cycles in the wait state.
  localparam logic [CNT_W-1:0] RD_LOAD = (READ_LATENCY  > 0) ? CNT_W'(READ_LATENCY  - 1) : '0;
  localparam logic [CNT_W-1:0] WR_LOAD = (WRITE_LATENCY > 0) ? CNT_W'(WRITE_LATENCY - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    RD_DONE,
    WR_WAIT,
    WR_COMMIT,
    WR_DONE
  } state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [1:0]           beat, beat_next;
  logic                 rd_accept, wr_accept;

  // Backing store and request-capture registers
  logic [CORE_DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];
  logic [IDX_W-3:0]           rd_line;
  logic [IDX_W-1:0]           rd_idx;
  logic [CORE_DATA_WIDTH-1:0] mem_rd_word;
  logic [CORE_DATA_WIDTH-1:0] line_q [3];
  logic [IDX_W-1:0]           wr_idx;
  logic [2:0]                 wr_off;
  logic [CORE_DATA_WIDTH-1:0] wr_data;
  logic [7:0]                 wr_strobe;
  logic [7:0]                 wr_mask;
  logic [CORE_DATA_WIDTH-1:0] wr_lane;

  // Address bits outside the word index are deliberately ignored so that
  // addresses wrap modulo the store size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_mem_read_address[ADDR_WIDTH-1:IDX_W+3],
                              i_mem_read_address[4:0],
                              i_mem_write_address[ADDR_WIDTH-1:IDX_W+3]};

  // Burst beat n reads word base+n; base has its two low index bits clear.
  assign rd_idx      = {rd_line, beat};
  assign mem_rd_word = mem[rd_idx];

  // Shift the right-aligned store into its byte lane; bits shifted past the
  // top of the word are dropped by the assignment width.
  assign wr_mask = wr_strobe << wr_off;
  assign wr_lane = wr_data << {wr_off, 3'b000};

  assign o_busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned, which would otherwise infer a latch.
    state_next = state;
    cnt_next   = cnt;
    beat_next  = beat;
    rd_accept  = 1'b0;
    wr_accept  = 1'b0;

    unique case (state)
      IDLE: begin
        // Write takes priority; a concurrent read stays pending.
        if (i_mem_write_valid) begin
          wr_accept = 1'b1;
          cnt_next  = WR_LOAD;
          state_next = (WRITE_LATENCY == 0) ? WR_COMMIT : WR_WAIT;
        end else if (i_mem_read_req) begin
          rd_accept  = 1'b1;
          cnt_next   = RD_LOAD;
          beat_next  = '0;
          state_next = (READ_LATENCY == 0) ? RD_BURST : RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (!i_mem_read_req) begin
          state_next = IDLE;
        end else if (cnt == '0) begin
          beat_next  = '0;
          state_next = RD_BURST;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end

      RD_BURST: begin
        if (!i_mem_read_req) begin
          state_next = IDLE;
        end else if (beat == 2'd3) begin
          state_next = RD_DONE;
        end else begin
          beat_next = beat + 1'b1;
        end
      end

      WR_WAIT: begin
        if (!i_mem_write_valid) begin
          state_next = IDLE;
        end else if (cnt == '0) begin
          state_next = WR_COMMIT;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end

      // Once in commit the store is irrevocable, even if the request drops.
      WR_COMMIT: state_next = WR_DONE;

      RD_DONE,
      WR_DONE:   state_next = IDLE;

      default:   state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control state and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the values from before this edge.
    if (!i_rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      beat             <= '0;
      o_mem_read_done  <= 1'b0;
      o_mem_write_done <= 1'b0;
      o_mem_read_data  <= '0;
    end else begin
      state            <= state_next;
      cnt              <= cnt_next;
      beat             <= beat_next;
      o_mem_read_done  <= (state_next == RD_DONE);
      o_mem_write_done <= (state_next == WR_DONE);
      // The last beat goes straight to the output alongside the buffered
      // lanes, so the visible line changes only when a read completes.
      if (state == RD_BURST && state_next == RD_DONE) begin
        o_mem_read_data <= {mem_rd_word, line_q[2], line_q[1], line_q[0]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: request capture, burst buffer and backing store
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: the store and the captured request fields have no reset; they are
    // only consumed under control of the reset state machine, and resetting a
    // memory array is neither required nor cheap.
    if (wr_accept) begin
      wr_idx    <= i_mem_write_address[IDX_W+2:3];
      wr_off    <= i_mem_write_address[2:0];
      wr_data   <= i_mem_write_data;
      wr_strobe <= i_mem_write_strobe;
    end
    if (rd_accept) begin
      rd_line <= i_mem_read_address[IDX_W+2:5];
    end
    if (state == RD_BURST && beat != 2'd3) begin
      line_q[beat] <= mem_rd_word;
    end
    // A reset arriving in the commit cycle cancels the store.
    if (state == WR_COMMIT && i_rst_n) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_lane[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_riscv_core_dmem_responder
//
// Self-checking bench for riscv_core_dmem_responder. A default-latency
// instance is driven through directed scenarios and a randomized mix of reads
// and writes; a second instance with zero read/write latency covers the
// shortest paths. Expected memory contents come from a word array updated
// byte by byte from the store rules; expected latencies come from the
// documented cycle counts.
// -----------------------------------------------------------------------------
module tb_riscv_core_dmem_responder;

  localparam int RL = 4;
  localparam int WL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         rd_req, rd_done, wr_valid, wr_done, busy;
  logic [63:0]  rd_addr, wr_addr, wr_data;
  logic [7:0]   wr_strobe;
  logic [255:0] rd_data;

  logic         z_rd_req, z_rd_done, z_wr_valid, z_wr_done, z_busy;
  logic [63:0]  z_rd_addr, z_wr_addr, z_wr_data;
  logic [7:0]   z_wr_strobe;
  logic [255:0] z_rd_data;

  riscv_core_dmem_responder #(
    .READ_LATENCY (RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_mem_read_req     (rd_req),
    .i_mem_read_address (rd_addr),
    .o_mem_read_done    (rd_done),
    .o_mem_read_data    (rd_data),
    .i_mem_write_valid  (wr_valid),
    .i_mem_write_address(wr_addr),
    .i_mem_write_data   (wr_data),
    .i_mem_write_strobe (wr_strobe),
    .o_mem_write_done   (wr_done),
    .o_busy             (busy)
  );

  riscv_core_dmem_responder #(
    .READ_LATENCY (0),
    .WRITE_LATENCY(0)
  ) dut_zero (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_mem_read_req     (z_rd_req),
    .i_mem_read_address (z_rd_addr),
    .o_mem_read_done    (z_rd_done),
    .o_mem_read_data    (z_rd_data),
    .i_mem_write_valid  (z_wr_valid),
    .i_mem_write_address(z_wr_addr),
    .i_mem_write_data   (z_wr_data),
    .i_mem_write_strobe (z_wr_strobe),
    .o_mem_write_done   (z_wr_done),
    .o_busy             (z_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference store and the line the read port is expected to be holding.
  logic [63:0]  mdl [4096];
  logic [255:0] exp_line = '0;

  function automatic int widx(input logic [63:0] a);
    return int'((a >> 3) & 64'hFFF);
  endfunction

  function automatic void model_write(input logic [63:0] a, input logic [63:0] d,
                                      input logic [7:0] s);
    int w;
    int off;
    w   = widx(a);
    off = int'(a & 64'h7);
    for (int b = 0; b < 8; b++) begin
      if (s[b] && (off + b) < 8) mdl[w][8*(off+b) +: 8] = d[8*b +: 8];
    end
  endfunction

  function automatic logic [255:0] model_line(input logic [63:0] a);
    logic [255:0] l;
    int base;
    base = widx(a) - (widx(a) % 4);
    for (int n = 0; n < 4; n++) l[64*n +: 64] = mdl[(base + n) % 4096];
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one write; lat is the cycle of the done pulse (-1 if none). Leaves
  // the bench one cycle after done so the DUT is back in IDLE.
  task automatic do_write(input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] s, output int lat);
    wr_addr = a; wr_data = d; wr_strobe = s; wr_valid = 1'b1; lat = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (wr_done) begin lat = n; break; end
    end
    wr_valid = 1'b0;
    if (lat >= 0) model_write(a, d, s);
    step();
  endtask

  task automatic do_read(input logic [63:0] a, output int lat, output logic [255:0] line);
    rd_addr = a; rd_req = 1'b1; lat = -1; line = '0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (rd_done) begin lat = n; line = rd_data; break; end
    end
    rd_req = 1'b0;
    if (lat >= 0) exp_line = model_line(a);
    step();
  endtask

  function automatic logic [63:0] rand_addr(input int idx, input int off);
    logic [63:0] a;
    a = {$urandom, $urandom};
    a[14:3] = 12'(idx);
    a[2:0]  = 3'(off);
    return a;
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if (busy !== 1'b0 || rd_done !== 1'b0 || wr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/rd_done/wr_done = %b%b%b, expected 000", busy, rd_done, wr_done);
    end
    n_checks++;
    if (rd_data !== 256'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", rd_data);
    end
    n_checks++;
    if (z_busy !== 1'b0 || z_rd_data !== 256'h0) begin
      n_fail++;
      $display("FAIL reset_zero_dut: busy %b data %h expected 0/0", z_busy, z_rd_data);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_preload();
    int lat;
    logic [63:0] d;
    for (int i = 0; i < 64; i++) begin
      d = (i < 4) ? 64'(8'hA0 + i) : {$urandom, $urandom};
      do_write(64'((256 + i) * 8), d, 8'hFF, lat);
      n_checks++;
      if (lat !== WL + 2) begin
        n_fail++;
        $display("FAIL preload_latency[%0d]: got %0d expected %0d", i, lat, WL + 2);
      end
    end
  endtask

  task automatic test_read_basic();
    int lat;
    logic [255:0] line;
    do_read(64'h800, lat, line);
    n_checks++;
    if (lat !== RL + 5) begin
      n_fail++;
      $display("FAIL read_latency: got %0d expected %0d", lat, RL + 5);
    end
    n_checks++;
    if (line !== {64'hA3, 64'hA2, 64'hA1, 64'hA0}) begin
      n_fail++;
      $display("FAIL read_line: got %h expected A3/A2/A1/A0", line);
    end
    n_checks++;
    if (rd_done !== 1'b0 || rd_data !== exp_line) begin
      n_fail++;
      $display("FAIL read_hold: done %b data %h expected 0 / %h", rd_done, rd_data, exp_line);
    end
    // High address bits are ignored: the same line comes back.
    do_read(64'hF000_0000_0000_8800, lat, line);
    n_checks++;
    if (line !== {64'hA3, 64'hA2, 64'hA1, 64'hA0}) begin
      n_fail++;
      $display("FAIL read_wrap: got %h expected A3/A2/A1/A0", line);
    end
  endtask

  task automatic test_write_mask();
    int lat;
    logic [255:0] line;
    do_write(64'h808, 64'h1111_2222_3333_4444, 8'hFF, lat);
    do_write(64'h80A, 64'hBEEF, 8'h03, lat);
    n_checks++;
    if (lat !== WL + 2) begin
      n_fail++;
      $display("FAIL write_latency: got %0d expected %0d", lat, WL + 2);
    end
    do_read(64'h800, lat, line);
    n_checks++;
    if (line[127:64] !== 64'h1111_2222_BEEF_4444) begin
      n_fail++;
      $display("FAIL write_halfword: got %h expected 1111_2222_beef_4444", line[127:64]);
    end
  endtask

  task automatic test_write_byte();
    int lat;
    logic [255:0] line;
    do_write(64'h80F, 64'h77, 8'h01, lat);
    do_read(64'h800, lat, line);
    n_checks++;
    if (line[127:64] !== 64'h7711_2222_BEEF_4444) begin
      n_fail++;
      $display("FAIL write_top_byte: got %h expected 7711_2222_beef_4444", line[127:64]);
    end
    n_checks++;
    if (line !== model_line(64'h800)) begin
      n_fail++;
      $display("FAIL write_byte_line: got %h expected %h", line, model_line(64'h800));
    end
  endtask

  task automatic test_priority();
    int wlat, rlat;
    logic [255:0] got;
    logic [63:0] wd;
    wd = {$urandom, $urandom};
    wr_addr = 64'h910; wr_data = wd; wr_strobe = 8'hFF; rd_addr = 64'h900;
    wr_valid = 1'b1; rd_req = 1'b1; wlat = -1; rlat = -1; got = '0;
    for (int n = 1; n <= 60; n++) begin
      step();
      if (wr_done && wlat < 0) begin
        wlat = n; wr_valid = 1'b0;
        model_write(64'h910, wd, 8'hFF);
      end
      if (rd_done) begin rlat = n; got = rd_data; break; end
    end
    rd_req = 1'b0;
    exp_line = model_line(64'h900);
    step();
    n_checks++;
    if (wlat !== WL + 2) begin
      n_fail++;
      $display("FAIL priority_write_first: write done at %0d expected %0d", wlat, WL + 2);
    end
    n_checks++;
    if (rlat !== WL + 2 + 1 + RL + 5) begin
      n_fail++;
      $display("FAIL priority_read_after: read done at %0d expected %0d", rlat, WL + RL + 8);
    end
    n_checks++;
    if (got !== exp_line) begin
      n_fail++;
      $display("FAIL priority_coherence: got %h expected %h", got, exp_line);
    end
  endtask

  task automatic test_read_abort();
    int seen;
    seen = 0;
    rd_addr = 64'h820; rd_req = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      step();
      if (n == 3) rd_req = 1'b0;
      if (rd_done) seen++;
      if (n == 5) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL read_abort_busy: busy %b at cycle 5 expected 0", busy);
        end
      end
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL read_abort_done: %0d done pulses expected 0", seen);
    end
    n_checks++;
    if (rd_data !== exp_line) begin
      n_fail++;
      $display("FAIL read_abort_data: got %h expected %h", rd_data, exp_line);
    end
  endtask

  task automatic test_write_abort();
    int seen, lat;
    logic [255:0] line;
    seen = 0;
    wr_addr = 64'h820; wr_data = ~mdl[widx(64'h820)]; wr_strobe = 8'hFF; wr_valid = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (n == 1) wr_valid = 1'b0;
      if (wr_done) seen++;
    end
    n_checks++;
    if (seen !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL write_abort: %0d done pulses, busy %b, expected 0/0", seen, busy);
    end
    do_read(64'h820, lat, line);
    n_checks++;
    if (line !== exp_line) begin
      n_fail++;
      $display("FAIL write_abort_store: got %h expected %h", line, exp_line);
    end
  endtask

  task automatic test_commit_abort();
    int lat;
    logic [63:0] wd;
    logic [255:0] line;
    wd = {$urandom, $urandom};
    wr_addr = 64'h828; wr_data = wd; wr_strobe = 8'h0F; wr_valid = 1'b1; lat = -1;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (n == WL + 1) wr_valid = 1'b0;
      if (wr_done) begin lat = n; break; end
    end
    wr_valid = 1'b0;
    step();
    model_write(64'h828, wd, 8'h0F);
    n_checks++;
    if (lat !== WL + 2) begin
      n_fail++;
      $display("FAIL commit_abort_done: done at %0d expected %0d", lat, WL + 2);
    end
    do_read(64'h820, lat, line);
    n_checks++;
    if (line !== exp_line) begin
      n_fail++;
      $display("FAIL commit_abort_store: got %h expected %h", line, exp_line);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [255:0] line;
    // Reset during the read burst.
    rd_addr = 64'h840; rd_req = 1'b1;
    for (int n = 1; n <= 6; n++) step();
    rst_n = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || rd_done !== 1'b0 || wr_done !== 1'b0 || rd_data !== 256'h0) begin
      n_fail++;
      $display("FAIL reset_mid_burst: busy %b rd_done %b wr_done %b data %h expected all 0",
               busy, rd_done, wr_done, rd_data);
    end
    rd_req = 1'b0; rst_n = 1'b1; exp_line = '0;
    step();
    // Reset in the commit cycle: the store must not happen.
    wr_addr = 64'h848; wr_data = ~mdl[widx(64'h848)]; wr_strobe = 8'hFF; wr_valid = 1'b1;
    for (int n = 1; n <= WL + 1; n++) step();
    rst_n = 1'b0;
    step();
    wr_valid = 1'b0; rst_n = 1'b1;
    step();
    do_read(64'h840, lat, line);
    n_checks++;
    if (line !== exp_line || lat !== RL + 5) begin
      n_fail++;
      $display("FAIL reset_mid_write: got %h lat %0d expected %h lat %0d", line, lat, exp_line, RL + 5);
    end
  endtask

  task automatic test_zero_latency();
    int lat;
    logic [63:0] w [4];
    for (int k = 0; k < 4; k++) begin
      w[k] = {$urandom, $urandom};
      z_wr_addr = 64'(64'h40 + 8 * k); z_wr_data = w[k]; z_wr_strobe = 8'hFF;
      z_wr_valid = 1'b1; lat = -1;
      for (int n = 1; n <= 20; n++) begin
        step();
        if (z_wr_done) begin lat = n; break; end
      end
      z_wr_valid = 1'b0;
      step();
      n_checks++;
      if (lat !== 2) begin
        n_fail++;
        $display("FAIL zero_write_latency[%0d]: got %0d expected 2", k, lat);
      end
    end
    z_rd_addr = 64'h40; z_rd_req = 1'b1; lat = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (z_rd_done) begin lat = n; break; end
    end
    z_rd_req = 1'b0;
    step();
    n_checks++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL zero_read_latency: got %0d expected 5", lat);
    end
    n_checks++;
    if (z_rd_data !== {w[3], w[2], w[1], w[0]}) begin
      n_fail++;
      $display("FAIL zero_read_line: got %h expected %h", z_rd_data, {w[3], w[2], w[1], w[0]});
    end
  endtask

  task automatic test_random();
    int lat, idx, off;
    logic [63:0] a, d;
    logic [7:0] s;
    logic [255:0] line;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        idx = 256 + int'($urandom_range(0, 63));
        off = int'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0:       s = 8'h01;
          1:       s = 8'h03;
          2:       s = 8'h0F;
          default: s = 8'hFF;
        endcase
        a = rand_addr(idx, off);
        d = {$urandom, $urandom};
        do_write(a, d, s, lat);
        n_checks++;
        if (lat !== WL + 2) begin
          n_fail++;
          $display("FAIL random_write_latency[%0d]: got %0d expected %0d", it, lat, WL + 2);
        end
      end else begin
        idx = 256 + 4 * int'($urandom_range(0, 15));
        a = rand_addr(idx, 0);
        a[4:0] = 5'd0;
        do_read(a, lat, line);
        n_checks++;
        if (lat !== RL + 5 || line !== model_line(a)) begin
          n_fail++;
          $display("FAIL random_read[%0d]: lat %0d line %h expected lat %0d line %h",
                   it, lat, line, RL + 5, model_line(a));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strobe = '0;
    z_rd_req = 1'b0; z_rd_addr = '0; z_wr_valid = 1'b0; z_wr_addr = '0; z_wr_data = '0;
    z_wr_strobe = '0;
    @(negedge clk);
    test_reset();
    test_preload();
    test_read_basic();
    test_write_mask();
    test_write_byte();
    test_priority();
    test_read_abort();
    test_write_abort();
    test_commit_abort();
    test_reset_mid();
    test_zero_latency();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
